// File: rtl/chunked_signed_unsigned_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock, MSB chunk first, signed or unsigned.
// Optional build macro: CMP_EARLY_EXIT_EN (stop at the first differing chunk).
module chunked_signed_unsigned_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = $clog2(NCHUNK + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic             busy,
    output logic             done,
    output logic             Equal,
    output logic             Greater,
    output logic             Smaller,
    output logic [CW-1:0]    cycles
);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_signed_unsigned_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg,   state_next;
    logic [WIDTH-1:0] a_reg,       a_next;
    logic [WIDTH-1:0] b_reg,       b_next;
    logic [CW-1:0]    idx_reg,     idx_next;
    logic             seen_reg,    seen_next;
    logic             seen_gt_reg, seen_gt_next;
    logic             equal_reg,   equal_next;
    logic             greater_reg, greater_next;
    logic             smaller_reg, smaller_next;
    logic [CW-1:0]    cycles_reg,  cycles_next;

    // Operands split into chunks; chunk gi holds bits gi*CHUNK+CHUNK-1 : gi*CHUNK.
    logic [CHUNK-1:0] chunk_a [NCHUNK];
    logic [CHUNK-1:0] chunk_b [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk_a[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign chunk_b[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic [CHUNK-1:0] sel_a;
    logic [CHUNK-1:0] sel_b;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == CW'(i)) begin
                sel_a = chunk_a[i];
                sel_b = chunk_b[i];
            end
        end
    end

    logic chunk_diff;
    logic chunk_gt;
    logic exit_now;
    logic last_chunk;
    logic accept;
    logic final_gt;

    assign chunk_diff = (sel_a != sel_b);
    assign chunk_gt   = (sel_a > sel_b);
    assign last_chunk = (idx_reg == '0);
    assign accept     = start && (state_reg != ST_CMP);

`ifdef CMP_EARLY_EXIT_EN
    assign exit_now = chunk_diff;
`else
    assign exit_now = 1'b0;
`endif

    // The most significant differing chunk decides; a difference recorded earlier wins.
    assign final_gt = seen_reg ? seen_gt_reg : chunk_gt;

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        idx_next     = idx_reg;
        seen_next    = seen_reg;
        seen_gt_next = seen_gt_reg;
        equal_next   = equal_reg;
        greater_next = greater_reg;
        smaller_next = smaller_reg;
        cycles_next  = cycles_reg;

        case (state_reg)
            ST_CMP: begin
                if (exit_now || last_chunk) begin
                    if (seen_reg || chunk_diff) begin
                        equal_next   = 1'b0;
                        greater_next = final_gt;
                        smaller_next = ~final_gt;
                    end else begin
                        equal_next   = 1'b1;
                        greater_next = 1'b0;
                        smaller_next = 1'b0;
                    end
                    cycles_next = CW'(NCHUNK) - idx_reg;
                    state_next  = ST_DONE;
                end else begin
                    if (chunk_diff && !seen_reg) begin
                        seen_next    = 1'b1;
                        seen_gt_next = chunk_gt;
                    end
                    idx_next = idx_reg - 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Accepted from IDLE or DONE; flipping the MSB turns signed order into unsigned order.
        if (accept) begin
            a_next       = {A[WIDTH-1] ^ S, A[WIDTH-2:0]};
            b_next       = {B[WIDTH-1] ^ S, B[WIDTH-2:0]};
            idx_next     = CW'(NCHUNK - 1);
            seen_next    = 1'b0;
            seen_gt_next = 1'b0;
            state_next   = ST_CMP;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx_reg     <= '0;
            seen_reg    <= 1'b0;
            seen_gt_reg <= 1'b0;
            equal_reg   <= 1'b0;
            greater_reg <= 1'b0;
            smaller_reg <= 1'b0;
            cycles_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            idx_reg     <= idx_next;
            seen_reg    <= seen_next;
            seen_gt_reg <= seen_gt_next;
            equal_reg   <= equal_next;
            greater_reg <= greater_next;
            smaller_reg <= smaller_next;
            cycles_reg  <= cycles_next;
        end
    end

    assign busy    = (state_reg == ST_CMP);
    assign done    = (state_reg == ST_DONE);
    assign Equal   = equal_reg;
    assign Greater = greater_reg;
    assign Smaller = smaller_reg;
    assign cycles  = cycles_reg;

endmodule

// File: tb/tb_chunked_signed_unsigned_comparator.sv
// Directed bench for chunked_signed_unsigned_comparator (WIDTH=16, CHUNK=4), either early-exit build.
module tb_chunked_signed_unsigned_comparator;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int CW = 3;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          S = 1'b0;
    logic          busy;
    logic          done;
    logic          Equal;
    logic          Greater;
    logic          Smaller;
    logic [CW-1:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;

    chunked_signed_unsigned_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .A(A), .B(B), .S(S),
        .busy(busy), .done(done), .Equal(Equal), .Greater(Greater),
        .Smaller(Smaller), .cycles(cycles)
    );

    always #5 CLK = ~CLK;

    // Result word layout: {Equal, Greater, Smaller, cycles}
    function automatic logic [5:0] res_word();
        return {Equal, Greater, Smaller, cycles};
    endfunction

    // Stimulus only: issue one op, report latency, result at done and done level one cycle later.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output logic [5:0] res, output logic done_after);
        @(negedge CLK);
        A = a; B = b; S = s; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        res = res_word();
        @(negedge CLK);
        done_after = done;
        $display("op A=%h B=%h S=%0d -> E=%0d G=%0d L=%0d cycles=%0d latency=%0d",
                 a, b, s, res[5], res[4], res[3], res[2:0], lat);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({busy, done, Equal, Greater, Smaller, cycles} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, want 00000000", {busy, done, Equal, Greater, Smaller, cycles});
        end
        RST_N = 1'b1;
    endtask

    task automatic test_msb_boundary();
        int lat; logic [5:0] res; logic da;
        int exp_k;
        exp_k = EARLY ? 1 : 4;
        run_op(16'h8000, 16'h7FFF, 1'b0, lat, res, da);
        n_checks++;
        if (res !== {3'b010, CW'(exp_k)}) begin
            n_fail++; $display("FAIL unsigned_msb_result: got %b, want %b", res, {3'b010, CW'(exp_k)});
        end
        n_checks++;
        if (lat != exp_k) begin
            n_fail++; $display("FAIL unsigned_msb_latency: got %0d, want %0d", lat, exp_k);
        end
        n_checks++;
        if (da !== 1'b0) begin
            n_fail++; $display("FAIL done_single_pulse: got %b, want 0", da);
        end
        run_op(16'h8000, 16'h7FFF, 1'b1, lat, res, da);
        n_checks++;
        if (res !== {3'b001, CW'(exp_k)}) begin
            n_fail++; $display("FAIL signed_msb_result: got %b, want %b", res, {3'b001, CW'(exp_k)});
        end
        n_checks++;
        if (lat != exp_k) begin
            n_fail++; $display("FAIL signed_msb_latency: got %0d, want %0d", lat, exp_k);
        end
    endtask

    task automatic test_equal();
        int lat; logic [5:0] res; logic da;
        for (int s = 0; s < 2; s++) begin
            run_op(16'h1234, 16'h1234, s[0], lat, res, da);
            n_checks++;
            if (res !== 6'b100_100 || lat != 4) begin
                n_fail++;
                $display("FAIL equal_s%0d: got res=%b latency=%0d, want res=100100 latency=4", s, res, lat);
            end
        end
    endtask

    task automatic test_ordering();
        int lat; logic [5:0] res; logic da;
        run_op(16'hFFFF, 16'hFFFE, 1'b1, lat, res, da);
        n_checks++;
        if (res !== 6'b010_100 || lat != 4) begin
            n_fail++; $display("FAIL signed_neg_order: got res=%b latency=%0d, want res=010100 latency=4", res, lat);
        end
        run_op(16'h0001, 16'h0002, 1'b0, lat, res, da);
        n_checks++;
        if (res !== 6'b001_100 || lat != 4) begin
            n_fail++; $display("FAIL unsigned_small_order: got res=%b latency=%0d, want res=001100 latency=4", res, lat);
        end
    endtask

    task automatic test_busy_ignore_back_to_back();
        int lat;
        int exp_k1;
        int exp_k2;
        exp_k1 = EARLY ? 3 : 4;
        exp_k2 = EARLY ? 2 : 4;
        @(negedge CLK);
        A = 16'h0010; B = 16'h0020; S = 1'b0; start = 1'b1;
        @(negedge CLK);
        lat = 0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_accept: got %b, want 1", busy);
        end
        A = 16'hFFFF; B = 16'h0000; S = 1'b1; start = 1'b1;
        @(negedge CLK);
        lat = 1;
        start = 1'b0;
        while (!done && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        $display("op A=0010 B=0020 S=0 (start pulsed while busy) -> E=%0d G=%0d L=%0d cycles=%0d latency=%0d",
                 Equal, Greater, Smaller, cycles, lat);
        n_checks++;
        if (res_word() !== {3'b001, CW'(exp_k1)} || lat != exp_k1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got res=%b latency=%0d, want res=%b latency=%0d",
                     res_word(), lat, {3'b001, CW'(exp_k1)}, exp_k1);
        end
        // Start while done is high: must be accepted straight into the next comparison.
        A = 16'h0300; B = 16'h0200; S = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        lat = 0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        while (!done && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        $display("op A=0300 B=0200 S=0 (back-to-back) -> E=%0d G=%0d L=%0d cycles=%0d latency=%0d",
                 Equal, Greater, Smaller, cycles, lat);
        n_checks++;
        if (res_word() !== {3'b010, CW'(exp_k2)} || lat != exp_k2) begin
            n_fail++;
            $display("FAIL back_to_back_result: got res=%b latency=%0d, want res=%b latency=%0d",
                     res_word(), lat, {3'b010, CW'(exp_k2)}, exp_k2);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int lat; logic [5:0] res; logic da;
        logic saw_done;
        @(negedge CLK);
        A = 16'h1234; B = 16'h1234; S = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, Equal, Greater, Smaller, cycles} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got %b, want 00000000", {busy, done, Equal, Greater, Smaller, cycles});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 3) RST_N = 1'b1;
            saw_done = saw_done | done;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: got done seen=%b, want 0", saw_done);
        end
        run_op(16'h0005, 16'h0003, 1'b0, lat, res, da);
        n_checks++;
        if (res !== 6'b010_100 || lat != 4) begin
            n_fail++; $display("FAIL after_reset_op: got res=%b latency=%0d, want res=010100 latency=4", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_msb_boundary();
        test_equal();
        test_ordering();
        test_busy_ignore_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
